fifo_unpack: RTL and testbench

FIFO_UNPACK -- requirements
Module: fifo_unpack

---
 rtl/fifo_unpack.sv | 128 ++++++++++++
 tb/tb_fifo_unpack.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpack.sv
// fifo_unpack
//   Reads in_width-bit words from an upstream fifo_sc (fixed one-cycle read
//   latency) and delivers them downstream as in_width/out_width slices,
//   most significant slice first. A two-entry word buffer plus a one-deep
//   read-in-flight credit keeps one slice per cycle flowing while the
//   upstream fifo is non-empty and the consumer is ready.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous reset, active-low
//   flush       synchronous discard of buffered and in-flight data
//   fifo_rd_en  read enable to the upstream fifo
//   fifo_dout   upstream read data, meaningful when fifo_valid=1
//   fifo_valid  upstream read acknowledge, one cycle after fifo_rd_en
//   fifo_empty  upstream empty flag
//   out_data    current slice (zero while out_valid=0)
//   out_valid   out_data holds a valid slice
//   out_ready   downstream accepts the slice when out_valid=1
//   words       number of words currently buffered (0..2)
module fifo_unpack #(
  parameter int in_width  = 32,
  parameter int out_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  output logic                 fifo_rd_en,
  input  logic [in_width-1:0]  fifo_dout,
  input  logic                 fifo_valid,
  input  logic                 fifo_empty,
  output logic [out_width-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           words
);

  localparam int N     = in_width / out_width;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((N < 2) || (N * out_width != in_width)) begin : g_param_check
    $error("fifo_unpack: in_width must be an integer multiple (>= 2) of out_width");
  end

  logic [in_width-1:0] word_buf [2];
  logic                head;
  logic [1:0]          count;
  logic                inflight;
  logic                drop;
  logic [IDX_W-1:0]    idx;

  logic [1:0] credit;
  logic [1:0] count_nxt;
  logic       wr_en;
  logic       pop;
  logic       pop_last;
  logic       tail;

  // Slice idx of a word, slice 0 being the most significant out_width bits.
  function automatic logic [out_width-1:0] slice_of(input logic [in_width-1:0] word,
                                                    input logic [IDX_W-1:0]    sel);
    logic [in_width-1:0] shifted;
    shifted = word << (int'(sel) * out_width);
    return shifted[in_width-1 -: out_width];
  endfunction

  // A read is only issued when the buffer can absorb it even if nothing is
  // popped meanwhile, so count can never exceed 2.
  assign credit     = count + {1'b0, inflight};
  assign fifo_rd_en = rst & ~flush & ~fifo_empty & (credit < 2'd2);

  // The count guard is unreachable under the credit rule; it only keeps a
  // misbehaving upstream from overwriting the head word.
  assign wr_en    = fifo_valid & ~drop & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign pop      = out_valid & out_ready;
  assign pop_last = pop & (idx == LAST_IDX);

  // Tail is the entry after the buffered words: head when empty, the other
  // entry when one word is held.
  assign tail = head ^ count[0];

  assign out_data = out_valid ? slice_of(word_buf[head], idx) : '0;
  assign words    = count;

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop_last})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_buf[0] <= '0;
      word_buf[1] <= '0;
      head        <= 1'b0;
      count       <= 2'd0;
      inflight    <= 1'b0;
      drop        <= 1'b0;
      idx         <= '0;
    end else if (flush) begin
      // A word still on its way back from the fifo must not land in the
      // freshly emptied buffer, hence drop follows the in-flight read.
      head     <= 1'b0;
      count    <= 2'd0;
      idx      <= '0;
      drop     <= inflight;
      inflight <= fifo_rd_en;
    end else begin
      inflight <= fifo_rd_en;
      drop     <= 1'b0;
      if (wr_en) begin
        word_buf[tail] <= fifo_dout;
      end
      if (pop) begin
        idx <= pop_last ? '0 : idx + 1'b1;
      end
      if (pop_last) begin
        head <= ~head;
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
module tb_fifo_unpack;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int N  = IW / OW;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          fifo_rd_en;
  logic [IW-1:0] fifo_dout;
  logic          fifo_valid;
  logic          fifo_empty;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    words;

  fifo_unpack #(.in_width(IW), .out_width(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_empty (fifo_empty),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .words      (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Upstream fifo model
  logic [IW-1:0] uq[$];
  logic          pend_v;
  logic [IW-1:0] pend_d;
  logic          underflow_next;
  int            force_empty;

  // Reference model: the stream of slices still owed downstream
  logic [OW-1:0] sq[$];
  int            m_inflight;
  int            m_drop;

  // Values sampled in the last cycle
  logic          s_rd;
  logic          s_valid;
  logic [OW-1:0] s_data;
  logic [1:0]    s_words;

  logic [OW-1:0] got_q[$];

  typedef struct {
    bit          push;
    logic [31:0] word;
    bit          fl;
    bit          rdy;
    bit          e_rd;
    bit          e_v;
    logic [7:0]  e_d;
    logic [1:0]  e_w;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic fl, input logic rdy);
    int m_words;
    bit exp_rd;
    logic [IW-1:0] tmp;
    @(negedge clk);
    fifo_valid = pend_v;
    fifo_dout  = pend_v ? pend_d : IW'($urandom);
    flush      = fl;
    out_ready  = rdy;
    fifo_empty = (uq.size() == 0) || (force_empty > 0);
    #1;
    s_rd    = fifo_rd_en;
    s_valid = out_valid;
    s_data  = out_data;
    s_words = words;
    m_words = (sq.size() + N - 1) / N;
    exp_rd  = !fl && !fifo_empty && ((m_words + m_inflight) < 2);
    chk("rd_en", {31'd0, s_rd}, {31'd0, exp_rd});
    chk("out_valid", {31'd0, s_valid}, {31'd0, sq.size() != 0});
    if (sq.size() != 0) chk("out_data", 32'(s_data), 32'(sq[0]));
    chk("words", 32'(s_words), 32'(m_words));
    // upstream fifo answers the read the DUT actually issued
    if (force_empty > 0) force_empty--;
    if (s_rd) begin
      if (underflow_next) begin
        pend_v = 1'b0;
        underflow_next = 1'b0;
        force_empty = 2;
      end else if (uq.size() > 0) begin
        pend_v = 1'b1;
        pend_d = uq.pop_front();
      end else begin
        pend_v = 1'b0;
      end
    end else begin
      pend_v = 1'b0;
    end
    // reference model update
    if (fl) begin
      sq.delete();
      m_drop = m_inflight;
    end else begin
      if (sq.size() != 0 && rdy) void'(sq.pop_front());
      if (fifo_valid && m_drop == 0) begin
        for (int i = 0; i < N; i++) begin
          tmp = fifo_dout >> ((N - 1 - i) * OW);
          sq.push_back(tmp[OW-1:0]);
        end
      end
      m_drop = 0;
    end
    m_inflight = exp_rd ? 1 : 0;
  endtask

  task automatic run_collect(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      cycle(1'b0, 1'b1);
      if (s_valid) got_q.push_back(s_data);
    end
  endtask

  task automatic chk_word(input string name, input int base, input logic [IW-1:0] exp);
    logic [IW-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      w = w << OW;
      if (base + i < got_q.size()) w = w | IW'(got_q[base + i]);
    end
    chk(name, w, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_words"}, 32'(words), 32'd0);
  endtask

  initial begin
    logic [OW-1:0] exp_s[$];
    logic [IW-1:0] w;
    bit started;

    tbl[0]  = '{1'b1, 32'h11223344, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 2'd1};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[7]  = '{1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[8]  = '{1'b1, 32'h01020304, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 2'd1};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 2'd2};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 2'd2};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 2'd2};
    tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'hBB, 2'd2};
    tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'hCC, 2'd2};
    tbl[15] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'hDD, 2'd2};
    tbl[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 2'd1};
    tbl[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1};
    tbl[18] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 2'd1};
    tbl[19] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 2'd1};
    tbl[20] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fifo_valid = 1'b0; fifo_dout = '0; fifo_empty = 1'b0;
    pend_v = 1'b0; pend_d = '0; underflow_next = 1'b0; force_empty = 0;
    m_inflight = 0; m_drop = 0;

    // Reset state, with fifo_empty low so rd_en must be held off by reset
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    fifo_empty = 1'b1;
    #1 rst = 1'b1;

    // Directed table: single word at full rate, then two words with backpressure
    for (int k = 0; k < 21; k++) begin
      if (tbl[k].push) uq.push_back(tbl[k].word);
      cycle(tbl[k].fl, tbl[k].rdy);
      chk($sformatf("tbl%0d_rd_en", k), {31'd0, s_rd}, {31'd0, tbl[k].e_rd});
      chk($sformatf("tbl%0d_out_valid", k), {31'd0, s_valid}, {31'd0, tbl[k].e_v});
      if (tbl[k].e_v) chk($sformatf("tbl%0d_out_data", k), 32'(s_data), 32'(tbl[k].e_d));
      chk($sformatf("tbl%0d_words", k), 32'(s_words), 32'(tbl[k].e_w));
    end

    // Flush while one word is buffered and the next one is returning
    uq.push_back(32'hDEADBEEF);
    uq.push_back(32'hCAFEF00D);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("flush_words", 32'(s_words), 32'd0);
    chk("flush_out_valid", {31'd0, s_valid}, 32'd0);
    uq.push_back(32'h0BADC0DE);
    got_q.delete();
    run_collect(10);
    chk("flush_next_count", got_q.size(), N);
    chk_word("flush_next_word", 0, 32'h0BADC0DE);

    // Read acknowledged with fifo_valid low (underflow)
    uq.push_back(32'h13579BDF);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    underflow_next = 1'b1;
    uq.push_back(32'h2468ACE0);
    cycle(1'b0, 1'b0);
    chk("uflow_rd_issued", {31'd0, s_rd}, 32'd1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("uflow_words", 32'(s_words), 32'd1);
    chk("uflow_out_data", 32'(s_data), 32'h13);
    got_q.delete();
    run_collect(14);
    chk("uflow_count", got_q.size(), 2 * N);
    chk_word("uflow_word0", 0, 32'h13579BDF);
    chk_word("uflow_word1", N, 32'h2468ACE0);

    // Sustained stream: no bubble once the first slice appears
    exp_s.delete();
    for (int i = 0; i < 6; i++) begin
      w = IW'($urandom);
      uq.push_back(w);
      for (int j = 0; j < N; j++) exp_s.push_back(OW'(w >> ((N - 1 - j) * OW)));
    end
    got_q.delete();
    started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b0, 1'b1);
      if (s_valid) started = 1'b1;
      if (started && got_q.size() < 6 * N) chk("stream_no_bubble", {31'd0, s_valid}, 32'd1);
      if (s_valid) got_q.push_back(s_data);
    end
    chk("stream_count", got_q.size(), 6 * N);
    for (int i = 0; i < 6 * N; i++) begin
      if (i < got_q.size()) chk($sformatf("stream_slice%0d", i), 32'(got_q[i]), 32'(exp_s[i]));
    end

    // Reset pulsed while the third slice of a word is on the output
    uq.push_back(32'hA1B2C3D4);
    for (int c = 0; c < 5; c++) cycle(1'b0, c < 4);
    chk("rst_mid_slice2", 32'(s_data), 32'hC3);
    uq.delete();
    uq.push_back(32'h55667788);
    pend_v = 1'b0;
    fifo_valid = 1'b0;
    fifo_empty = 1'b0;
    #1 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    sq.delete();
    m_inflight = 0;
    m_drop = 0;
    @(posedge clk);
    #1 chk_all_zero("rst_held");
    rst = 1'b1;
    got_q.delete();
    run_collect(8);
    chk("rst_restart_first", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'h55);
    chk_word("rst_restart_word", 0, 32'h55667788);

    // Randomized traffic against the reference model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) < 4 && uq.size() < 4) uq.push_back(IW'($urandom));
      if ($urandom_range(0, 19) == 0) underflow_next = 1'b1;
      cycle($urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7);
    end
    underflow_next = 1'b0;
    for (int c = 0; c < 30; c++) cycle(1'b0, 1'b1);
    chk("drain_words", 32'(s_words), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
